// File: rtl/gray_tick_pkg.sv
// Shared types and helpers for gray_tick_accumulator: FSM state encodings,
// Gray conversion and the dropped-tick counter width.
package gray_tick_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

    localparam int OVR_CNT_W  = 8;
    localparam int GRAY_MAX_W = 32;

    // Callers size-cast in and out, so one function serves every width up to GRAY_MAX_W.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// Rising-edge detector for the upstream terminal-count tick: a level held
// high for several cycles yields one single-cycle strobe.
module tick_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic tick_in,
    output logic tick_pulse
);

    logic r_tick_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_q <= 1'b0;
        end else begin
            r_tick_q <= tick_in;
        end
    end

    assign tick_pulse = tick_in & ~r_tick_q;

endmodule

// File: rtl/gray_tick_accumulator.sv
// Counts accepted ticks into TERMINAL-long frames and hands out a Gray-coded
// frame sequence number per frame. Optional macro: GRAY_TICK_OVERRUN_CNT_EN.
module gray_tick_accumulator
    import gray_tick_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int TERMINAL = 3,
    parameter int SEQ_W    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick_in,
    input  logic                 enable,
    input  logic                 done_ready,
    output logic [WIDTH-1:0]     count_bin,
    output logic [WIDTH-1:0]     count_gray,
    output logic                 done_valid,
    output logic [SEQ_W-1:0]     done_seq,
    output logic                 overrun,
    output logic [OVR_CNT_W-1:0] overrun_cnt,
    output logic [1:0]           dbg_state
);

    // done_valid/done_ready: the result is held stable while done_valid is high;
    // a transfer happens on any edge where both are high, and done_valid then falls.

    localparam logic [WIDTH-1:0] TERMINAL_M1 = WIDTH'(TERMINAL - 1);

    logic              w_tick_pulse;
    logic              w_drop;
    state_t            r_state, w_state_next;
    logic [WIDTH-1:0]  r_count, w_count_next;
    logic [SEQ_W-1:0]  r_seq_bin, w_seq_bin_next, w_seq_inc;
    logic [SEQ_W-1:0]  r_done_seq, w_done_seq_next;
    logic              r_done_valid, w_done_valid_next;
    logic              r_overrun;

    tick_edge_detect u_edge (
        .clk        (clk),
        .reset      (reset),
        .tick_in    (tick_in),
        .tick_pulse (w_tick_pulse)
    );

    assign w_seq_inc = r_seq_bin + SEQ_W'(1);

    always_comb begin
        w_state_next      = r_state;
        w_count_next      = r_count;
        w_seq_bin_next    = r_seq_bin;
        w_done_seq_next   = r_done_seq;
        w_done_valid_next = r_done_valid;
        w_drop            = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_count_next = '0;
                if (enable) w_state_next = ST_COUNT;
            end
            ST_COUNT: begin
                // Dropping enable wins over a tick arriving in the same cycle.
                if (!enable) begin
                    w_state_next = ST_IDLE;
                    w_count_next = '0;
                end else if (w_tick_pulse) begin
                    if (r_count == TERMINAL_M1) begin
                        w_count_next      = '0;
                        w_seq_bin_next    = w_seq_inc;
                        w_done_seq_next   = SEQ_W'(bin2gray(GRAY_MAX_W'(w_seq_inc)));
                        w_done_valid_next = 1'b1;
                        w_state_next      = ST_HOLD;
                    end else begin
                        w_count_next = r_count + WIDTH'(1);
                    end
                end
            end
            ST_HOLD: begin
                w_drop = w_tick_pulse;
                if (r_done_valid && done_ready) begin
                    w_done_valid_next = 1'b0;
                    w_state_next      = enable ? ST_COUNT : ST_IDLE;
                end
            end
            default: begin
                w_state_next      = ST_IDLE;
                w_count_next      = '0;
                w_done_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_seq_bin    <= '0;
            r_done_seq   <= '0;
            r_done_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_count      <= w_count_next;
            r_seq_bin    <= w_seq_bin_next;
            r_done_seq   <= w_done_seq_next;
            r_done_valid <= w_done_valid_next;
            if (w_drop) r_overrun <= 1'b1;
        end
    end

`ifdef GRAY_TICK_OVERRUN_CNT_EN
    logic [OVR_CNT_W-1:0] r_ovr_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovr_cnt <= '0;
        end else if (w_drop && (r_ovr_cnt != '1)) begin
            r_ovr_cnt <= r_ovr_cnt + OVR_CNT_W'(1);
        end
    end

    assign overrun_cnt = r_ovr_cnt;
`else
    assign overrun_cnt = '0;
`endif

    assign count_bin  = r_count;
    assign count_gray = WIDTH'(bin2gray(GRAY_MAX_W'(r_count)));
    assign done_valid = r_done_valid;
    assign done_seq   = r_done_seq;
    assign overrun    = r_overrun;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_gray_tick_accumulator.sv
// Self-checking bench for gray_tick_accumulator: directed scenarios plus a
// randomized run, all compared against a frame-level reference model.
module tb_gray_tick_accumulator;

    localparam int WIDTH    = 4;
    localparam int TERMINAL = 3;
    localparam int SEQ_W    = 4;

    localparam int M_IDLE  = 0;
    localparam int M_COUNT = 1;
    localparam int M_HOLD  = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             tick_in = 1'b0;
    logic             enable = 1'b0;
    logic             done_ready = 1'b0;
    logic [WIDTH-1:0] count_bin;
    logic [WIDTH-1:0] count_gray;
    logic             done_valid;
    logic [SEQ_W-1:0] done_seq;
    logic             overrun;
    logic [7:0]       overrun_cnt;
    logic [1:0]       dbg_state;

    int errors = 0;
    int checks = 0;
    int phase  = 0;

    int m_mode   = M_IDLE;
    int m_cnt    = 0;
    int m_frames = 0;
    int m_drops  = 0;
    bit m_tick_prev = 1'b0;

    gray_tick_accumulator #(
        .WIDTH    (WIDTH),
        .TERMINAL (TERMINAL),
        .SEQ_W    (SEQ_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick_in     (tick_in),
        .enable      (enable),
        .done_ready  (done_ready),
        .count_bin   (count_bin),
        .count_gray  (count_gray),
        .done_valid  (done_valid),
        .done_seq    (done_seq),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic int gray_of(int v);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [23:0] exp_word();
        logic [7:0] oc;
        logic [1:0] st;
`ifdef GRAY_TICK_OVERRUN_CNT_EN
        oc = 8'((m_drops > 255) ? 255 : m_drops);
`else
        oc = 8'd0;
`endif
        st = (m_mode == M_HOLD) ? 2'b10 : (m_mode == M_COUNT) ? 2'b01 : 2'b00;
        return {4'(m_cnt), 4'(gray_of(m_cnt)), (m_mode == M_HOLD),
                4'(gray_of(m_frames % (1 << SEQ_W))), (m_drops > 0), oc, st};
    endfunction

    function automatic logic [23:0] act_word();
        return {count_bin, count_gray, done_valid, done_seq, overrun, overrun_cnt, dbg_state};
    endfunction

    // One clock edge: the model consumes the same inputs the DUT sampled.
    task automatic step();
        bit pulse;
        @(posedge clk);
        pulse = tick_in && !m_tick_prev;
        if (reset) begin
            m_mode = M_IDLE; m_cnt = 0; m_frames = 0; m_drops = 0; m_tick_prev = 1'b0;
        end else begin
            m_tick_prev = tick_in;
            if (m_mode == M_IDLE) begin
                if (enable) m_mode = M_COUNT;
            end else if (m_mode == M_COUNT) begin
                if (!enable) begin
                    m_mode = M_IDLE; m_cnt = 0;
                end else if (pulse) begin
                    m_cnt++;
                    if (m_cnt == TERMINAL) begin
                        m_cnt = 0; m_frames++; m_mode = M_HOLD;
                    end
                end
            end else begin
                if (pulse) m_drops++;
                if (done_ready) m_mode = enable ? M_COUNT : M_IDLE;
            end
        end
        #1;
    endtask

    // Upstream period-8 terminal-count tick.
    task automatic up_step();
        tick_in = (phase == 7);
        phase = (phase + 1) % 8;
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1; tick_in = 1'b0; phase = 0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; done_ready = 1'b0; tick_in = 1'b1;
        step(); step();
        checks++;
        if (act_word() !== 24'h0) begin
            errors++; $display("FAIL reset_state got=%h exp=%h", act_word(), 24'h0);
        end
        reset = 1'b0; enable = 1'b0; tick_in = 1'b0;
        step();
        checks++;
        if (act_word() !== exp_word()) begin
            errors++; $display("FAIL reset_idle got=%h exp=%h", act_word(), exp_word());
        end
    endtask

    task automatic test_frames();
        logic [SEQ_W-1:0] exp_q[$];
        int valid_at[$];
        exp_q = '{4'b0001, 4'b0011, 4'b0010};
        do_reset();
        enable = 1'b1; done_ready = 1'b1;
        for (int c = 0; c < 80; c++) begin
            up_step();
            checks++;
            if (act_word() !== exp_word()) begin
                errors++; $display("FAIL frames c=%0d got=%h exp=%h", c, act_word(), exp_word());
            end
            if (done_valid === 1'b1) begin
                valid_at.push_back(c);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL frames_extra_frame seq=%b exp=none", done_seq);
                end else if (done_seq !== exp_q[0]) begin
                    errors++; $display("FAIL frames_seq got=%b exp=%b", done_seq, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL frames_missing got=%0d exp=0 left", exp_q.size());
        end
        for (int i = 1; i < valid_at.size(); i++) begin
            checks++;
            if (valid_at[i] - valid_at[i-1] != 24) begin
                errors++; $display("FAIL frames_period got=%0d exp=24", valid_at[i] - valid_at[i-1]);
            end
        end
    endtask

    task automatic test_held_tick();
        do_reset();
        enable = 1'b1; done_ready = 1'b1; tick_in = 1'b0;
        step(); step();
        tick_in = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (act_word() !== exp_word()) begin
                errors++; $display("FAIL held c=%0d got=%h exp=%h", c, act_word(), exp_word());
            end
        end
        tick_in = 1'b0;
        step();
        checks++;
        if (count_bin !== 4'd1) begin
            errors++; $display("FAIL held_once got=%0d exp=1", count_bin);
        end
    endtask

    task automatic test_overrun();
        int guard;
        logic [SEQ_W-1:0] seq0;
        do_reset();
        enable = 1'b1; done_ready = 1'b0;
        guard = 0;
        while (done_valid !== 1'b1 && guard < 100) begin
            up_step(); guard++;
        end
        checks++;
        if (done_valid !== 1'b1) begin
            errors++; $display("FAIL overrun_no_frame got=%b exp=1", done_valid);
        end
        seq0 = done_seq;
        for (int c = 0; c < 20; c++) begin
            up_step();
            checks++;
            if (done_valid !== 1'b1 || done_seq !== seq0 || act_word() !== exp_word()) begin
                errors++; $display("FAIL overrun_hold c=%0d got=%h exp=%h seq=%b seq0=%b",
                                   c, act_word(), exp_word(), done_seq, seq0);
            end
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_flag got=%b exp=1", overrun);
        end
`ifdef GRAY_TICK_OVERRUN_CNT_EN
        checks++;
        if (overrun_cnt !== 8'd2 && overrun_cnt !== 8'd3) begin
            errors++; $display("FAIL overrun_cnt got=%0d exp=2or3", overrun_cnt);
        end
`else
        checks++;
        if (overrun_cnt !== 8'd0) begin
            errors++; $display("FAIL overrun_cnt_off got=%0d exp=0", overrun_cnt);
        end
`endif
        done_ready = 1'b1;
        up_step();
        checks++;
        if (dbg_state !== 2'b01 || count_bin !== 4'd0 || done_valid !== 1'b0) begin
            errors++; $display("FAIL overrun_release got=%b/%0d/%b exp=01/0/0",
                               dbg_state, count_bin, done_valid);
        end
    endtask

    task automatic test_enable_drop();
        int guard;
        do_reset();
        enable = 1'b1; done_ready = 1'b1;
        guard = 0;
        while (count_bin !== 4'd2 && guard < 60) begin
            up_step(); guard++;
        end
        checks++;
        if (count_bin !== 4'd2) begin
            errors++; $display("FAIL endrop_reach got=%0d exp=2", count_bin);
        end
        enable = 1'b0;
        up_step();
        checks++;
        if (dbg_state !== 2'b00 || count_bin !== 4'd0) begin
            errors++; $display("FAIL endrop_idle got=%b/%0d exp=00/0", dbg_state, count_bin);
        end
        for (int c = 0; c < 20; c++) begin
            up_step();
            checks++;
            if (count_bin !== 4'd0 || act_word() !== exp_word()) begin
                errors++; $display("FAIL endrop_ignore c=%0d got=%h exp=%h", c, act_word(), exp_word());
            end
        end
    endtask

    task automatic test_reset_in_hold();
        int guard;
        do_reset();
        enable = 1'b1; done_ready = 1'b0;
        guard = 0;
        while (done_valid !== 1'b1 && guard < 100) begin
            up_step(); guard++;
        end
        reset = 1'b1;
        up_step();
        reset = 1'b0;
        checks++;
        if (act_word() !== 24'h0) begin
            errors++; $display("FAIL rsthold_clear got=%h exp=%h", act_word(), 24'h0);
        end
        done_ready = 1'b1;
        guard = 0;
        while (done_valid !== 1'b1 && guard < 100) begin
            up_step(); guard++;
        end
        checks++;
        if (done_valid !== 1'b1 || done_seq !== 4'b0001) begin
            errors++; $display("FAIL rsthold_restart got=%b/%b exp=1/0001", done_valid, done_seq);
        end
    endtask

    task automatic test_wrap();
        logic [SEQ_W-1:0] seq_q[$];
        logic [SEQ_W-1:0] prev;
        do_reset();
        enable = 1'b1; done_ready = 1'b1;
        for (int c = 0; c < 16 * 24 + 40 && seq_q.size() < 16; c++) begin
            up_step();
            checks++;
            if (act_word() !== exp_word()) begin
                errors++; $display("FAIL wrap c=%0d got=%h exp=%h", c, act_word(), exp_word());
            end
            if (done_valid === 1'b1) seq_q.push_back(done_seq);
        end
        checks++;
        if (seq_q.size() != 16) begin
            errors++; $display("FAIL wrap_frames got=%0d exp=16", seq_q.size());
        end
        prev = '0;
        foreach (seq_q[i]) begin
            checks++;
            if ($countones(seq_q[i] ^ prev) != 1) begin
                errors++; $display("FAIL wrap_onebit i=%0d got=%b prev=%b exp=1 bit change", i, seq_q[i], prev);
            end
            prev = seq_q[i];
        end
        checks++;
        if (prev !== 4'b0000) begin
            errors++; $display("FAIL wrap_end got=%b exp=0000", prev);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick_in    = ($urandom_range(0, 3) == 0);
            enable     = ($urandom_range(0, 15) != 0);
            done_ready = ($urandom_range(0, 2) != 0);
            reset      = ($urandom_range(0, 199) == 0);
            step();
            checks++;
            if (act_word() !== exp_word()) begin
                errors++; $display("FAIL random c=%0d got=%h exp=%h", c, act_word(), exp_word());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frames();
        test_held_tick();
        test_overrun();
        test_enable_drop();
        test_reset_in_hold();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gray_tick_accumulator.md
# gray_tick_accumulator

Downstream consumer of the 3-bit Gray-code counter's terminal-count pulse. It edge-detects the 1-in-8 tick, counts ticks into programmable-length frames, and exposes the running count in binary and Gray form. At each frame boundary it issues a Gray-coded frame sequence number over a valid/ready handshake. Ticks arriving while a frame result is unacknowledged are dropped and flagged as overrun.

## Interface
- `WIDTH`, default 4: tick-count width in bits.
- `TERMINAL`, default 3: ticks per frame. Legal range 1..2^WIDTH-1.
- `SEQ_W`, default 4: frame sequence number width in bits.
- `clk`, input, 1: the single clock; all state updates on posedge.
- `reset`, input, 1: synchronous, active-high.
- `tick_in`, input, 1: tick from the upstream Gray counter `out`.
- `enable`, input, 1: counting enable.
- `done_ready`, input, 1: downstream accepts the frame result.
- `count_bin`, output, WIDTH: ticks accepted in the current frame.
- `count_gray`, output, WIDTH: Gray code of `count_bin`.
- `done_valid`, output, 1: a frame result is pending.
- `done_seq`, output, SEQ_W: Gray-coded frame sequence number.
- `overrun`, output, 1: sticky flag, set when any tick has been dropped.
- `overrun_cnt`, output, 8: dropped-tick count (see Configuration).

## Operation
- Accepted tick: `tick_in & ~tick_q`, where `tick_q` is `tick_in` registered once. A level held high for several cycles counts once.
- States are IDLE, COUNT and HOLD. The register is 2 bits wide; the 4th encoding recovers to IDLE.
- **IDLE**
  - `count_bin` is held at 0 and ticks are ignored. They are not overruns.
  - `enable`=1 moves the FSM to COUNT on the next edge.
- **COUNT**
  - An accepted tick increments `count_bin`.
  - A tick when `count_bin`==TERMINAL-1 does the following:
    - clears `count_bin` to 0;
    - increments the internal binary sequence number (wraps modulo 2^SEQ_W);
    - loads `done_seq` with its Gray code;
    - sets `done_valid`=1 and moves the FSM to HOLD.
  - `enable`=0 moves the FSM to IDLE and clears `count_bin`. It has priority over a same-cycle tick.
- **HOLD**
  - `done_valid`=1 and `done_seq` is stable.
  - `done_valid & done_ready` at an edge is a transfer: the FSM goes to COUNT, or to IDLE if `enable`=0. `done_valid` falls.
  - An accepted tick in HOLD is dropped: `overrun` is set and `overrun_cnt` increments. This includes the transfer cycle.
  - `enable`=0 in HOLD does not abandon the result. The FSM leaves only on a transfer.
- `count_gray` = `count_bin ^ (count_bin >> 1)`, taken from the registered `count_bin`. It changes exactly 1 bit per increment and on the TERMINAL→0 wrap only when TERMINAL is a power of two.
- `overrun` clears only on reset.

## Timing
- Reset state: FSM in IDLE. `tick_q`, `count_bin`, `count_gray`, `done_valid`, `done_seq`, the sequence register, `overrun` and `overrun_cnt` are all 0.
- Edge-to-count latency: a `tick_in` rise sampled at edge n+1 (low at edge n) updates `count_bin`/`count_gray` after edge n+1.
- Frame latency: `done_valid` is high in the cycle after the edge sampling the terminal tick.
- Minimum HOLD residency is 1 cycle, when `done_ready` is already high.
- With the upstream counter at period 8 and TERMINAL=3, a frame completes every 24 cycles. Ticks arrive 8 cycles apart, so `done_ready` must respond within 7 cycles to avoid overrun.
- `reset` asserted mid-frame or in HOLD takes effect at the next edge. It discards the pending result and returns all outputs to their reset values.
- All outputs are registered; there is no combinational input→output path.

## Configuration
- `GRAY_TICK_OVERRUN_CNT_EN` defined: `overrun_cnt` is an 8-bit counter of dropped ticks, saturating at 255.
- Undefined: `overrun_cnt` is tied to 0 and the counter logic is not compiled. The `overrun` flag is always present.

## Structure
- Package `gray_tick_pkg` holds:
  - the state typedef and its encodings (IDLE=2'b00, COUNT=2'b01, HOLD=2'b10);
  - the `bin2gray` function, parameterised by width;
  - the overrun counter width constant (8).
- One sub-module, `tick_edge_detect` (clk, reset, `tick_in` → `tick_pulse`), holds `tick_q` and produces the single-cycle accepted-tick strobe.

## Test plan
- **Reset, then enable=1:** drive the upstream period-8 tick with TERMINAL=3 and `done_ready` tied 1.
  - `count_bin` steps 0→1→2→0.
  - `done_valid` pulses for 1 cycle every 24 cycles.
  - `done_seq` steps 0001, 0011, 0010.
- **Held tick:** hold `tick_in` high for 5 cycles in COUNT → `count_bin` increments exactly once.
- **Overrun:** `done_ready`=0 for 20 cycles after the frame completes.
  - `done_valid` and `done_seq` stay stable.
  - 2 or 3 ticks are dropped, `overrun`=1, and `overrun_cnt` matches (0 when the macro is undefined).
  - After `done_ready`=1 the FSM returns to COUNT with `count_bin`=0.
- **Enable drop mid-frame:** drop `enable` at `count_bin`=2 → IDLE next cycle with `count_bin`=0, and ticks in IDLE are ignored.
- **Reset in HOLD:** assert `reset` 1 cycle while `done_valid`=1 → all outputs return to 0 after that edge, and the sequence restarts at 0001.
- **Wrap:** run 16 frames with SEQ_W=4 → `done_seq` completes the Gray cycle back to 0000, changing 1 bit per frame.
